// File: rtl/load_store_align.sv
// Load/store alignment unit: decodes RV-style loads/stores and lane-shifts store data, byte enables and load results.
// Define LSU_MISALIGNED_EN to split misaligned accesses into two memory beats; otherwise they fault.
module load_store_align #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_inst,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_fault
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam bit IS64  = (XLEN == 64);

  typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, RESP, FAULT} state_t;

  state_t state_reg, state_next;

  logic              mem_valid_reg, mem_valid_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [NB-1:0]     mem_be_reg, mem_be_next;
  logic [XLEN-1:0]   mem_wdata_reg, mem_wdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [XLEN-1:0]   rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_fault_reg, rsp_fault_next;

  logic              uns_reg, uns_next;
  logic [1:0]        size_reg, size_next;
  logic [OFF_W-1:0]  off_reg, off_next;
`ifdef LSU_MISALIGNED_EN
  logic              split_reg, split_next;
  logic [NB-1:0]     be1_reg, be1_next;
  logic [XLEN-1:0]   wdata1_reg, wdata1_next;
  logic [XLEN-1:0]   rdata0_reg, rdata0_next;
`endif

  // Request decode
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              is_load, is_store, legal, misaligned;
  logic [1:0]        req_size;
  logic [OFF_W-1:0]  req_off;
  logic [2*NB-1:0]   lanes_low, lane_mask2;
  logic [2*XLEN-1:0] wdata2;

  assign opcode   = req_inst[6:0];
  assign funct3   = req_inst[14:12];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign req_size = funct3[1:0];
  assign req_off  = req_addr[OFF_W-1:0];

  always_comb begin
    legal = 1'b0;
    if (is_load) begin
      case (funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = IS64;
        default:                                legal = 1'b0;
      endcase
    end else if (is_store) begin
      case (funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = IS64;
        default:                legal = 1'b0;
      endcase
    end
  end

  assign misaligned = (int'(req_off) + (int'(1) << req_size)) > NB;

  always_comb begin
    case (req_size)
      2'd0:    lanes_low = (2*NB)'(8'h01);
      2'd1:    lanes_low = (2*NB)'(8'h03);
      2'd2:    lanes_low = (2*NB)'(8'h0F);
      default: lanes_low = (2*NB)'(8'hFF);
    endcase
  end

  // Double-width shifts: the low half feeds beat0, the high half is what spills into beat1.
  assign lane_mask2 = lanes_low << req_off;
  assign wdata2     = {{XLEN{1'b0}}, req_wdata} << {req_off, 3'b000};

  // Load extraction and extension
  logic [XLEN-1:0]   rd_lo, rd_hi, raw, keep_mask, load_result;
  logic [2*XLEN-1:0] raw2;
  logic [NB-1:0]     byte_keep;
  logic              sign_bit;

`ifdef LSU_MISALIGNED_EN
  assign rd_lo = split_reg ? rdata0_reg : mem_rdata;
  assign rd_hi = split_reg ? mem_rdata : '0;
`else
  assign rd_lo = mem_rdata;
  assign rd_hi = '0;
`endif

  assign raw2 = {rd_hi, rd_lo} >> {off_reg, 3'b000};
  assign raw  = raw2[XLEN-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_keep
      assign byte_keep[gi]         = (gi < (int'(1) << size_reg));
      assign keep_mask[8*gi +: 8]  = {8{byte_keep[gi]}};
    end
  endgenerate

  always_comb begin
    case (size_reg)
      2'd0:    sign_bit = raw[7];
      2'd1:    sign_bit = raw[15];
      2'd2:    sign_bit = raw[31];
      default: sign_bit = raw[XLEN-1];
    endcase
  end

  assign load_result = (raw & keep_mask) | ({XLEN{sign_bit & ~uns_reg}} & ~keep_mask);

  // Next-state and registered-output logic
  always_comb begin
    state_next     = state_reg;
    mem_valid_next = mem_valid_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_be_next    = mem_be_reg;
    mem_wdata_next = mem_wdata_reg;
    rsp_valid_next = 1'b0;
    rsp_rdata_next = rsp_rdata_reg;
    rsp_fault_next = rsp_fault_reg;
    uns_next       = uns_reg;
    size_next      = size_reg;
    off_next       = off_reg;
`ifdef LSU_MISALIGNED_EN
    split_next     = split_reg;
    be1_next       = be1_reg;
    wdata1_next    = wdata1_reg;
    rdata0_next    = rdata0_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          uns_next  = funct3[2];
          size_next = req_size;
          off_next  = req_off;
`ifdef LSU_MISALIGNED_EN
          split_next  = misaligned;
          be1_next    = lane_mask2[2*NB-1:NB];
          wdata1_next = is_store ? wdata2[2*XLEN-1:XLEN] : '0;
          if (!legal) begin
`else
          if (!legal || misaligned) begin
`endif
            state_next     = FAULT;
            rsp_valid_next = 1'b1;
            rsp_fault_next = 1'b1;
            rsp_rdata_next = '0;
          end else begin
            state_next     = BEAT0;
            mem_valid_next = 1'b1;
            mem_we_next    = is_store;
            mem_addr_next  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_next    = lane_mask2[NB-1:0];
            mem_wdata_next = is_store ? wdata2[XLEN-1:0] : '0;
          end
        end
      end
      BEAT0: begin
        if (mem_ready) begin
`ifdef LSU_MISALIGNED_EN
          if (split_reg) begin
            state_next     = BEAT1;
            rdata0_next    = mem_rdata;
            mem_addr_next  = mem_addr_reg + ADDR_W'(NB);
            mem_be_next    = be1_reg;
            mem_wdata_next = wdata1_reg;
          end else begin
            state_next     = RESP;
            mem_valid_next = 1'b0;
            rsp_valid_next = 1'b1;
            rsp_fault_next = 1'b0;
            rsp_rdata_next = mem_we_reg ? '0 : load_result;
          end
`else
          state_next     = RESP;
          mem_valid_next = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_fault_next = 1'b0;
          rsp_rdata_next = mem_we_reg ? '0 : load_result;
`endif
        end
      end
`ifdef LSU_MISALIGNED_EN
      BEAT1: begin
        if (mem_ready) begin
          state_next     = RESP;
          mem_valid_next = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_fault_next = 1'b0;
          rsp_rdata_next = mem_we_reg ? '0 : load_result;
        end
      end
`endif
      RESP, FAULT: state_next = IDLE;
      default:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      mem_valid_reg <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_be_reg    <= '0;
      mem_wdata_reg <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_fault_reg <= 1'b0;
      uns_reg       <= 1'b0;
      size_reg      <= '0;
      off_reg       <= '0;
`ifdef LSU_MISALIGNED_EN
      split_reg     <= 1'b0;
      be1_reg       <= '0;
      wdata1_reg    <= '0;
      rdata0_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      mem_valid_reg <= mem_valid_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_be_reg    <= mem_be_next;
      mem_wdata_reg <= mem_wdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_rdata_reg <= rsp_rdata_next;
      rsp_fault_reg <= rsp_fault_next;
      uns_reg       <= uns_next;
      size_reg      <= size_next;
      off_reg       <= off_next;
`ifdef LSU_MISALIGNED_EN
      split_reg     <= split_next;
      be1_reg       <= be1_next;
      wdata1_reg    <= wdata1_next;
      rdata0_reg    <= rdata0_next;
`endif
    end
  end

  assign req_ready = (state_reg == IDLE);
  assign mem_valid = mem_valid_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_be    = mem_be_reg;
  assign mem_wdata = mem_wdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_fault = rsp_fault_reg;

endmodule

// File: tb/tb_load_store_align.sv
// Directed bench for load_store_align: a 32-bit instance for most vectors, a 64-bit instance for LD/LWU.
module tb_load_store_align;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit DUT
  logic        req_valid = 1'b0, req_ready;
  logic [31:0] req_inst = '0, req_addr = '0, req_wdata = '0;
  logic        mem_valid, mem_ready = 1'b0, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        rsp_valid, rsp_fault;
  logic [31:0] rsp_rdata;

  logic [31:0] lo_data = '0, hi_addr = 32'hDEAD_0000, hi_data = '0;
  always_comb mem_rdata = (mem_addr == hi_addr) ? hi_data : lo_data;

  load_store_align #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault)
  );

  // 64-bit DUT
  logic        r64_valid = 1'b0, r64_ready;
  logic [31:0] r64_inst = '0, r64_addr = '0;
  logic [63:0] r64_wdata = '0;
  logic        m64_valid, m64_ready = 1'b1, m64_we;
  logic [31:0] m64_addr;
  logic [7:0]  m64_be;
  logic [63:0] m64_wdata, m64_rdata = '0;
  logic        s64_valid, s64_fault;
  logic [63:0] s64_rdata;

  load_store_align #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk(clk), .reset(reset),
    .req_valid(r64_valid), .req_ready(r64_ready), .req_inst(r64_inst),
    .req_addr(r64_addr), .req_wdata(r64_wdata),
    .mem_valid(m64_valid), .mem_ready(m64_ready), .mem_we(m64_we),
    .mem_addr(m64_addr), .mem_be(m64_be), .mem_wdata(m64_wdata), .mem_rdata(m64_rdata),
    .rsp_valid(s64_valid), .rsp_rdata(s64_rdata), .rsp_fault(s64_fault)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'b0, f3, 5'b0, op};
  endfunction

  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  // Observations of the last transaction on the 32-bit DUT
  int          beats, lat, seen_valid, unstable;
  logic [31:0] b_addr [2];
  logic [3:0]  b_be   [2];
  logic [31:0] b_wdata[2];
  logic        b_we;
  logic [31:0] r_data;
  logic        r_fault, r_ready;

  task automatic run_req(input logic [31:0] inst, input logic [31:0] addr,
                         input logic [31:0] wdata, input int stall);
    int          stall_left;
    logic        p_valid, p_ready;
    logic [67:0] p_vec;
    beats = 0; lat = 0; seen_valid = 0; unstable = 0;
    r_data = '0; r_fault = 1'b0; r_ready = 1'b1; b_we = 1'b0;
    for (int i = 0; i < 2; i++) begin b_addr[i] = '0; b_be[i] = '0; b_wdata[i] = '0; end
    stall_left = stall; p_valid = 1'b0; p_ready = 1'b0; p_vec = '0;
    mem_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_inst = inst; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int cyc = 1; cyc <= 30 && lat == 0; cyc++) begin
      @(negedge clk);
      if (mem_valid) begin
        seen_valid = 1;
        if (p_valid && !p_ready && ({mem_addr, mem_be, mem_wdata} != p_vec)) unstable = 1;
        mem_ready = (stall_left == 0);
        if (!mem_ready) stall_left--;
        if (mem_ready) begin
          if (beats < 2) begin
            b_addr[beats] = mem_addr; b_be[beats] = mem_be; b_wdata[beats] = mem_wdata;
          end
          b_we = mem_we;
          beats++;
        end
      end
      p_valid = mem_valid; p_ready = mem_ready; p_vec = {mem_addr, mem_be, mem_wdata};
      if (rsp_valid) begin
        lat = cyc; r_data = rsp_rdata; r_fault = rsp_fault; r_ready = req_ready;
      end
    end
    mem_ready = 1'b0;
    $display("txn inst=%08h addr=%08h beats=%0d lat=%0d rdata=%08h fault=%0b",
             inst, addr, beats, lat, r_data, r_fault);
    @(negedge clk);
  endtask

  logic [63:0] r64_data;
  logic        r64_fault;
  int          lat64;

  task automatic run64(input logic [31:0] inst, input logic [31:0] addr, input logic [63:0] rdata);
    lat64 = 0; r64_data = '0; r64_fault = 1'b0; m64_rdata = rdata;
    @(negedge clk);
    r64_valid = 1'b1; r64_inst = inst; r64_addr = addr;
    @(posedge clk);
    #1 r64_valid = 1'b0;
    for (int cyc = 1; cyc <= 10 && lat64 == 0; cyc++) begin
      @(negedge clk);
      if (s64_valid) begin lat64 = cyc; r64_data = s64_rdata; r64_fault = s64_fault; end
    end
    $display("txn64 inst=%08h addr=%08h lat=%0d rdata=%016h fault=%0b",
             inst, addr, lat64, r64_data, r64_fault);
    @(negedge clk);
  endtask

  initial begin
    int saw_rsp;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_mem_valid", 64'(mem_valid), 64'd0);
    check("rst_mem_addr",  64'(mem_addr),  64'd0);
    check("rst_mem_be",    64'(mem_be),    64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // LB / LBU at 0x1003
    lo_data = 32'h8011_2233;
    run_req(mk(3'b000, OP_LD), 32'h1003, '0, 0);
    check("lb_addr",  64'(b_addr[0]), 64'h1000);
    check("lb_be",    64'(b_be[0]),   64'h8);
    check("lb_data",  64'(r_data),    64'hFFFF_FF80);
    check("lb_lat",   64'(lat),       64'd2);
    check("lb_beats", 64'(beats),     64'd1);
    check("lb_ready_during_rsp", 64'(r_ready), 64'd0);
    run_req(mk(3'b100, OP_LD), 32'h1003, '0, 0);
    check("lbu_data", 64'(r_data), 64'h80);

    // LHU with three stalled cycles
    run_req(mk(3'b101, OP_LD), 32'h1002, '0, 3);
    check("lhu_data",   64'(r_data),   64'h8011);
    check("lhu_lat",    64'(lat),      64'd5);
    check("lhu_stable", 64'(unstable), 64'd0);

    // SH at 0x1001
    run_req(mk(3'b001, OP_ST), 32'h1001, 32'h0000_BEEF, 0);
    check("sh_be",    64'(b_be[0]),    64'h6);
    check("sh_wdata", 64'(b_wdata[0]), 64'h00BE_EF00);
    check("sh_we",    64'(b_we),       64'd1);
    check("sh_rdata", 64'(r_data),     64'd0);
    check("sh_fault", 64'(r_fault),    64'd0);

    // Misaligned LW and SW
    lo_data = 32'hAABB_CCDD; hi_addr = 32'h1004; hi_data = 32'h1122_3344;
    run_req(mk(3'b010, OP_LD), 32'h1002, '0, 0);
`ifdef LSU_MISALIGNED_EN
    check("lw_mis_beats", 64'(beats),     64'd2);
    check("lw_mis_addr1", 64'(b_addr[1]), 64'h1004);
    check("lw_mis_data",  64'(r_data),    64'h3344_AABB);
    check("lw_mis_lat",   64'(lat),       64'd3);
`else
    check("lw_mis_fault", 64'(r_fault),    64'd1);
    check("lw_mis_novld", 64'(seen_valid), 64'd0);
    check("lw_mis_lat",   64'(lat),        64'd1);
`endif
    run_req(mk(3'b010, OP_ST), 32'h1003, 32'h1234_5678, 0);
`ifdef LSU_MISALIGNED_EN
    check("sw_mis_be0", 64'(b_be[0]),    64'h8);
    check("sw_mis_wd0", 64'(b_wdata[0]), 64'h7800_0000);
    check("sw_mis_be1", 64'(b_be[1]),    64'h7);
    check("sw_mis_wd1", 64'(b_wdata[1]), 64'h0012_3456);
    check("sw_mis_a1",  64'(b_addr[1]),  64'h1004);
    // LH straddling the top of the address space wraps to 0
    lo_data = 32'hAB00_0000; hi_addr = 32'h0; hi_data = 32'h0000_00CD;
    run_req(mk(3'b001, OP_LD), 32'hFFFF_FFFF, '0, 0);
    check("wrap_addr0", 64'(b_addr[0]), 64'hFFFF_FFFC);
    check("wrap_addr1", 64'(b_addr[1]), 64'h0);
    check("wrap_data",  64'(r_data),    64'hFFFF_CDAB);
    hi_addr = 32'hDEAD_0000;
`else
    check("sw_mis_fault", 64'(r_fault),    64'd1);
    check("sw_mis_novld", 64'(seen_valid), 64'd0);
`endif

    // Illegal encodings
    run_req(mk(3'b011, OP_LD), 32'h2000, '0, 0);
    check("ld32_fault", 64'(r_fault), 64'd1);
    check("ld32_rdata", 64'(r_data),  64'd0);
    check("ld32_lat",   64'(lat),     64'd1);
    run_req(mk(3'b100, OP_ST), 32'h2000, 32'hFFFF_FFFF, 0);
    check("st_f3_fault", 64'(r_fault), 64'd1);
    run_req(mk(3'b010, 7'b0110011), 32'h2000, '0, 0);
    check("badop_fault", 64'(r_fault), 64'd1);
    check("badop_novld", 64'(seen_valid), 64'd0);

    // Reset while waiting in BEAT0
    @(negedge clk);
    req_valid = 1'b1; req_inst = mk(3'b010, OP_LD); req_addr = 32'h3000; mem_ready = 1'b0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_mem_valid", 64'(mem_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_mem_valid", 64'(mem_valid), 64'd0);
    check("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_rsp = 0;
    mem_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid || mem_valid) saw_rsp = 1;
    end
    mem_ready = 1'b0;
    check("mid_rst_no_rsp",   64'(saw_rsp),   64'd0);
    check("mid_rst_req_ready", 64'(req_ready), 64'd1);
    $display("txn reset-in-beat0 done");

    // XLEN=64 instance
    run64(mk(3'b110, OP_LD), 32'h4, 64'hF000_0000_0000_0000);
    check("lwu64_data", r64_data, 64'h0000_0000_F000_0000);
    check("lwu64_lat",  64'(lat64), 64'd2);
    run64(mk(3'b010, OP_LD), 32'h4, 64'hF000_0000_0000_0000);
    check("lw64_data", r64_data, 64'hFFFF_FFFF_F000_0000);
    run64(mk(3'b011, OP_LD), 32'h0, 64'h8123_4567_89AB_CDEF);
    check("ld64_data",  r64_data, 64'h8123_4567_89AB_CDEF);
    check("ld64_fault", 64'(r64_fault), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
